// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives imem, registers instructions
// for decode, redirects on taken branches and halts on the RST opcode.
module fetch_unit #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 9
) (
  input  logic               CLK,
  input  logic               Reset_n,
  input  logic               Start,
  input  logic [PC_W-1:0]    StartAddr,
  input  logic               Stall,
  input  logic               BranchTaken,
  input  logic [PC_W-1:0]    BranchTarget,
  output logic [PC_W-1:0]    ImemAddr,
  input  logic [INSTR_W-1:0] ImemData,
  output logic [INSTR_W-1:0] Instr,
  output logic [PC_W-1:0]    InstrPC,
  output logic               InstrValid,
  output logic               Done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } state_t;

  state_t state_q, state_d;

  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    ipc_q, ipc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               is_rst;

  assign is_rst = (ImemData[INSTR_W-1 -: 4] == 4'b1111);

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ipc_q   <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ipc_q   <= ipc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (Start) state_d = S_RUN;
      S_RUN: begin
        if (!BranchTaken && !Stall && is_rst)
          state_d = S_HALT;
      end
      S_HALT: if (Start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    ipc_d   = ipc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    done_d  = done_q;
    unique case (state_q)
      S_IDLE: begin
        if (Start) pc_d = StartAddr;
      end
      S_RUN: begin
        // a taken branch squashes the word being fetched, even an RST
        if (BranchTaken) begin
          pc_d    = BranchTarget;
          valid_d = 1'b0;
        end else if (!Stall) begin
          instr_d = ImemData;
          ipc_d   = pc_q;
          valid_d = 1'b1;
          if (!is_rst) pc_d = pc_q + PC_W'(1);
        end
      end
      S_HALT: begin
        if (Start) begin
          pc_d    = StartAddr;
          done_d  = 1'b0;
          valid_d = 1'b0;
        end else if (!Stall) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign ImemAddr   = pc_q;
  assign Instr      = instr_q;
  assign InstrPC    = ipc_q;
  assign InstrValid = valid_q;
  assign Done       = done_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand sequences for squash
// and async reset, then random traffic against a behavioural model.
module tb_fetch_unit;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 9;
  localparam int DEPTH   = 1 << PC_W;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [PC_W-1:0]    saddr;
  logic               stall;
  logic               br;
  logic [PC_W-1:0]    tgt;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    instr_pc;
  logic               instr_valid;
  logic               done;

  logic [INSTR_W-1:0] rom [DEPTH];

  int vectors;
  int miscompares;

  fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
    .CLK(clk),
    .Reset_n(rst_n),
    .Start(start),
    .StartAddr(saddr),
    .Stall(stall),
    .BranchTaken(br),
    .BranchTarget(tgt),
    .ImemAddr(imem_addr),
    .ImemData(imem_data),
    .Instr(instr),
    .InstrPC(instr_pc),
    .InstrValid(instr_valid),
    .Done(done)
  );

  assign imem_data = rom[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: 0 idle, 1 running, 2 halted
  int m_mode;
  int m_pc;
  int m_ipc;
  int m_instr;
  int m_valid;
  int m_done;

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_ipc = 0;
    m_instr = 0; m_valid = 0; m_done = 0;
  endtask

  task automatic model_step();
    int w;
    if (m_mode == 0) begin
      if (start) begin
        m_pc = int'(saddr);
        m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (br) begin
        m_pc = int'(tgt);
        m_valid = 0;
      end else if (!stall) begin
        w = int'(rom[m_pc]);
        m_instr = w;
        m_ipc = m_pc;
        m_valid = 1;
        if ((w >> (INSTR_W - 4)) == 15) m_mode = 2;
        else m_pc = (m_pc + 1) % DEPTH;
      end
    end else begin
      if (start) begin
        m_pc = int'(saddr);
        m_done = 0;
        m_valid = 0;
        m_mode = 1;
      end else if (!stall) begin
        m_valid = 0;
        m_done = 1;
      end
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("model.addr", 32'(imem_addr), 32'(m_pc));
    chk("model.instr", 32'(instr), 32'(m_instr));
    chk("model.ipc", 32'(instr_pc), 32'(m_ipc));
    chk("model.valid", 32'(instr_valid), 32'(m_valid));
    chk("model.done", 32'(done), 32'(m_done));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk_model();
  endtask

  task automatic drive(logic s, logic [PC_W-1:0] sa, logic st,
                       logic b, logic [PC_W-1:0] t);
    start = s; saddr = sa; stall = st; br = b; tgt = t;
  endtask

  typedef struct {
    logic               s;
    logic [PC_W-1:0]    sa;
    logic               st;
    logic               b;
    logic [PC_W-1:0]    t;
    logic [PC_W-1:0]    e_addr;
    logic [PC_W-1:0]    e_ipc;
    logic [INSTR_W-1:0] e_instr;
    logic               e_valid;
    logic               e_done;
  } vec_t;

  function automatic vec_t mk(logic s, int sa, logic st, logic b, int t,
                              int a, int ipc, int ins, logic v, logic d);
    vec_t r;
    r.s = s; r.sa = PC_W'(sa); r.st = st; r.b = b; r.t = PC_W'(t);
    r.e_addr = PC_W'(a); r.e_ipc = PC_W'(ipc);
    r.e_instr = INSTR_W'(ins); r.e_valid = v; r.e_done = d;
    return r;
  endfunction

  vec_t tbl [38];

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < DEPTH; i++) rom[i] = '0;
    rom[4] = 9'h010; rom[5] = 9'h021; rom[6] = 9'h032; rom[7] = 9'h1E0;
    rom[20] = 9'h055; rom[21] = 9'h066;
    rom[1023] = 9'h0AA; rom[0] = 9'h0BB; rom[1] = 9'h0CC;
    rom[2] = 9'h0DD; rom[3] = 9'h1E5;
    rom[8] = 9'h077; rom[9] = 9'h088;

    tbl[0]  = mk(1, 4, 0, 0, 0,     4,    0, 'h000, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0,     5,    4, 'h010, 1, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0,     6,    5, 'h021, 1, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0,     7,    6, 'h032, 1, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0,     7,    7, 'h1E0, 1, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0,     7,    7, 'h1E0, 0, 1);
    tbl[6]  = mk(0, 0, 0, 0, 0,     7,    7, 'h1E0, 0, 1);
    tbl[7]  = mk(1, 4, 0, 0, 0,     4,    7, 'h1E0, 0, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0,     5,    4, 'h010, 1, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0,     6,    5, 'h021, 1, 0);
    tbl[10] = mk(0, 0, 1, 0, 0,     6,    5, 'h021, 1, 0);
    tbl[11] = mk(0, 0, 1, 0, 0,     6,    5, 'h021, 1, 0);
    tbl[12] = mk(0, 0, 1, 0, 0,     6,    5, 'h021, 1, 0);
    tbl[13] = mk(0, 0, 0, 0, 0,     7,    6, 'h032, 1, 0);
    tbl[14] = mk(0, 0, 0, 0, 0,     7,    7, 'h1E0, 1, 0);
    tbl[15] = mk(0, 0, 0, 0, 0,     7,    7, 'h1E0, 0, 1);
    tbl[16] = mk(1, 4, 0, 0, 0,     4,    7, 'h1E0, 0, 0);
    tbl[17] = mk(0, 0, 0, 0, 0,     5,    4, 'h010, 1, 0);
    tbl[18] = mk(0, 0, 0, 0, 0,     6,    5, 'h021, 1, 0);
    tbl[19] = mk(0, 0, 0, 1, 20,    20,   5, 'h021, 0, 0);
    tbl[20] = mk(0, 0, 0, 0, 0,     21,  20, 'h055, 1, 0);
    tbl[21] = mk(0, 0, 1, 1, 4,     4,   20, 'h055, 0, 0);
    tbl[22] = mk(0, 0, 0, 0, 0,     5,    4, 'h010, 1, 0);
    tbl[23] = mk(0, 0, 0, 0, 0,     6,    5, 'h021, 1, 0);
    tbl[24] = mk(0, 0, 0, 0, 0,     7,    6, 'h032, 1, 0);
    tbl[25] = mk(0, 0, 0, 0, 0,     7,    7, 'h1E0, 1, 0);
    tbl[26] = mk(0, 0, 0, 0, 0,     7,    7, 'h1E0, 0, 1);
    tbl[27] = mk(0, 0, 0, 1, 50,    7,    7, 'h1E0, 0, 1);
    tbl[28] = mk(1, 1023, 0, 0, 0,  1023, 7, 'h1E0, 0, 0);
    tbl[29] = mk(0, 0, 0, 0, 0,     0, 1023, 'h0AA, 1, 0);
    tbl[30] = mk(0, 0, 0, 0, 0,     1,    0, 'h0BB, 1, 0);
    tbl[31] = mk(1, 4, 0, 0, 0,     2,    1, 'h0CC, 1, 0);
    tbl[32] = mk(0, 0, 0, 0, 0,     3,    2, 'h0DD, 1, 0);
    tbl[33] = mk(0, 0, 0, 0, 0,     3,    3, 'h1E5, 1, 0);
    tbl[34] = mk(0, 0, 1, 0, 0,     3,    3, 'h1E5, 1, 0);
    tbl[35] = mk(0, 0, 0, 0, 0,     3,    3, 'h1E5, 0, 1);
    tbl[36] = mk(1, 8, 0, 0, 0,     8,    3, 'h1E5, 0, 0);
    tbl[37] = mk(0, 0, 0, 0, 0,     9,    8, 'h077, 1, 0);

    rst_n = 1'b0;
    drive(0, '0, 0, 0, '0);
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst.addr", 32'(imem_addr), 32'd0);
    chk("rst.instr", 32'(instr), 32'd0);
    chk("rst.ipc", 32'(instr_pc), 32'd0);
    chk("rst.valid", 32'(instr_valid), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 38; i++) begin
      drive(tbl[i].s, tbl[i].sa, tbl[i].st, tbl[i].b, tbl[i].t);
      tick();
      chk($sformatf("tbl%0d.addr", i), 32'(imem_addr), 32'(tbl[i].e_addr));
      chk($sformatf("tbl%0d.ipc", i), 32'(instr_pc), 32'(tbl[i].e_ipc));
      chk($sformatf("tbl%0d.instr", i), 32'(instr), 32'(tbl[i].e_instr));
      chk($sformatf("tbl%0d.valid", i), 32'(instr_valid), 32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d.done", i), 32'(done), 32'(tbl[i].e_done));
    end

    // branch squashes an RST being fetched
    rom[6] = 9'h1F0;
    drive(0, '0, 0, 1, 10'd5);
    tick();
    drive(0, '0, 0, 0, '0);
    tick();
    chk("sq.ipc5", 32'(instr_pc), 32'd5);
    drive(0, '0, 0, 1, 10'd30);
    tick();
    chk("sq.bubble", 32'(instr_valid), 32'd0);
    drive(0, '0, 0, 0, '0);
    tick();
    chk("sq.ipc30", 32'(instr_pc), 32'd30);
    chk("sq.valid30", 32'(instr_valid), 32'd1);
    chk("sq.nodone", 32'(done), 32'd0);
    tick();

    // asynchronous reset mid-run, checked before the next edge
    rst_n = 1'b0;
    model_reset();
    #2;
    chk("arst.addr", 32'(imem_addr), 32'd0);
    chk("arst.instr", 32'(instr), 32'd0);
    chk("arst.ipc", 32'(instr_pc), 32'd0);
    chk("arst.valid", 32'(instr_valid), 32'd0);
    chk("arst.done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle.addr", 32'(imem_addr), 32'd0);
    end

    for (int i = 0; i < DEPTH; i++) begin
      if ($urandom_range(0, 7) == 0)
        rom[i] = {4'hF, 5'($urandom)};
      else
        rom[i] = INSTR_W'($urandom_range(0, 479));
    end
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 5) == 0, PC_W'($urandom),
            $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
            PC_W'($urandom));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
